d_capture_reader: RTL and testbench
===================================

Name: d_capture_reader

Overview:
- Read-side companion to the team's enable-gated D storage elements.
- Captures WIDTH-bit data words on an enable strobe into a small DEPTH-entry buffer.
- Delivers the stored words in capture order to a downstream consumer over a valid/ready handshake.
- Also exposes the most recently captured value as latch-style q/qn outputs.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, buffer entries; must be a power of two and at least 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- d  in  WIDTH  data to capture.
- e  in  1  capture enable, active high.
- clr  in  1  synchronous flush, active high.
- out_valid  out  1  buffer holds at least one word.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  WIDTH  oldest stored word.
- q  out  WIDTH  last captured word.
- qn  out  WIDTH  bitwise inverse of q.
- count  out  $clog2(DEPTH+1)  number of stored words.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky flag: a capture was dropped.

Behaviour:
- Reset (rst_n low, asynchronous): pointers = 0, count = 0, q = 0, qn = all ones, overflow = 0, out_valid = 0, full = 0. out_data content is don't-care while out_valid = 0.
- Push condition: e = 1 and (not full, or a pop occurs in the same cycle). On push: mem[wr_ptr] <= d, wr_ptr increments, q <= d.
- Pop condition: out_valid = 1 and out_ready = 1. On pop: rd_ptr increments.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop, or on neither.
- Show-ahead output:
  - out_data = mem[rd_ptr], driven combinationally from storage.
  - out_valid = (count != 0).
  - Latency from capture edge to out_valid high is 1 cycle.
- No bypass when empty: a word pushed while empty is not visible until the next cycle. A pop cannot occur while empty.
- Full with e = 1 and no pop:
  - d is dropped; q is not updated.
  - overflow <= 1 and stays set until clr or reset.
- Full with e = 1 and a pop in the same cycle: push accepted; count stays at DEPTH.
- clr = 1:
  - Next edge: pointers = 0, count = 0, overflow = 0; q is retained.
  - clr has priority over push and pop in the same cycle.
- qn is always ~q. It is driven continuously, not registered separately.
- Reset asserted mid-transfer: all state clears immediately. Buffered words are lost, and out_valid falls without waiting for a clock.

Optional Feature:
- Macro: D_CAPTURE_EDGE_EN.
- Defined:
  - A registered copy e_d of e is added; its reset value is 0.
  - The capture condition becomes e & ~e_d, so a push happens only on the first cycle of an e-high interval.
  - Holding e high for N cycles captures exactly 1 word.
- Not defined: a push happens on every cycle e = 1, subject to the full rules above.

Decomposition:
- Shared package d_capture_pkg:
  - DEPTH_MIN constant (value 2).
  - Pointer-width and count-width helper constants derived via $clog2.
  - Typedef for the handshake pair {valid, ready}.
- One natural sub-module, d_capture_mem:
  - DEPTH x WIDTH storage array.
  - Write port: we, waddr, wdata.
  - Asynchronous read port: raddr, rdata.
  - No reset on the array contents.
- Pointer, count, flag and q logic stay in the top module.

Test Plan:
1. Reset: assert rst_n = 0 mid-cycle with 2 words stored -> count = 0, out_valid = 0, q = 0x00, qn = 0xFF immediately, without a clock edge.
2. Single capture: d = 0xA5, e = 1 for 1 cycle, out_ready = 0 -> next cycle out_valid = 1, out_data = 0xA5, q = 0xA5, qn = 0x5A, count = 1. Then out_ready = 1 for 1 cycle -> count = 0, out_valid = 0.
3. Fill and overflow: capture 0x01..0x04 on 4 consecutive cycles, then 0x05 with out_ready = 0 -> full = 1, overflow = 1, q = 0x04. Drain returns 0x01, 0x02, 0x03, 0x04 in order.
4. Full with simultaneous push and pop: at full, e = 1 with d = 0x66 and out_ready = 1 -> count stays 4, overflow stays 0. Drain order ends with 0x66; pointers wrap correctly.
5. Flush: 3 words stored, overflow = 1, clr = 1 together with e = 1 (d = 0x77) -> count = 0, overflow = 0, q unchanged, 0x77 not stored.
6. Edge capture (D_CAPTURE_EDGE_EN defined): e held high 5 cycles with d = 0x10, 0x11, 0x12, 0x13, 0x14 -> count = 1, out_data = 0x10. With the macro undefined, the same stimulus -> count = 4 and overflow = 1.

Source files
------------

// File: rtl/d_capture_pkg.sv
// ============================================================================
// Module      : d_capture_pkg
// Description : Shared constants, width helpers and handshake type for the
//               d_capture_reader codebase slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package d_capture_pkg;

    localparam int DEPTH_MIN     = 2;
    localparam int DEPTH_DEFAULT = 4;

    // Depths below the minimum are clamped so the pointer is never zero-width.
    function automatic int ptr_width(input int depth);
        return $clog2((depth < DEPTH_MIN) ? DEPTH_MIN : depth);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int PTR_W_DEFAULT = $clog2(DEPTH_DEFAULT);
    localparam int CNT_W_DEFAULT = $clog2(DEPTH_DEFAULT + 1);

    typedef struct packed {
        logic valid;
        logic ready;
    } hs_t;

endpackage : d_capture_pkg

`default_nettype wire

// File: rtl/d_capture_mem.sv
// ============================================================================
// Module      : d_capture_mem
// Description : DEPTH x WIDTH storage, one synchronous write port and one
//               asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module d_capture_mem
    import d_capture_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [ptr_width(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]            wdata,
    input  logic [ptr_width(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]            rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : d_capture_mem

`default_nettype wire

// File: rtl/d_capture_reader.sv
// ============================================================================
// Module      : d_capture_reader
// Description : Captures enable-strobed words into a small buffer, delivers
//               them in order over valid/ready, and mirrors the last capture
//               on q/qn. Optional macro D_CAPTURE_EDGE_EN makes capture fire
//               only on the first cycle of each e-high interval.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module d_capture_reader
    import d_capture_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           d,
    input  logic                       e,
    input  logic                       clr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           qn,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       overflow
);

    localparam int c_ptr_w = ptr_width(DEPTH);
    localparam int c_cnt_w = count_width(DEPTH);

    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_q;
    logic               r_overflow;

    logic               w_cap;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    hs_t                w_out_hs;

`ifdef D_CAPTURE_EDGE_EN
    logic r_e_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_d <= 1'b0;
        end else begin
            r_e_d <= e;
        end
    end

    assign w_cap = e & ~r_e_d;
`else
    assign w_cap = e;
`endif

    assign w_full         = (r_count == c_cnt_w'(DEPTH));
    assign w_out_hs.valid = (r_count != '0);
    assign w_out_hs.ready = out_ready;
    assign w_pop          = w_out_hs.valid & w_out_hs.ready;
    // A pop frees a slot in the same cycle, so a full buffer may still accept.
    assign w_push         = w_cap & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_q        <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                r_q      <= d;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            if (w_cap && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    d_capture_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (w_push & ~clr),
        .waddr (r_wr_ptr),
        .wdata (d),
        .raddr (r_rd_ptr),
        .rdata (out_data)
    );

    assign out_valid = w_out_hs.valid;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign q         = r_q;
    assign qn        = ~r_q;

endmodule : d_capture_reader

`default_nettype wire

// File: tb/tb_d_capture_reader.sv
// ============================================================================
// Module      : tb_d_capture_reader
// Description : Directed self-checking bench for d_capture_reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_d_capture_reader;

    logic       clk;
    logic       rst_n;
    logic [7:0] d;
    logic       e;
    logic       clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] q;
    logic [7:0] qn;
    logic [2:0] count;
    logic       full;
    logic       overflow;

    int tests  = 0;
    int failed = 0;

    d_capture_reader #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .e         (e),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .q         (q),
        .qn        (qn),
        .count     (count),
        .full      (full),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One capture strobe followed by an idle cycle, valid in both capture modes.
    task automatic capture(input logic [7:0] val);
        d = val;
        e = 1'b1;
        step();
        e = 1'b0;
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        d         = 8'h00;
        e         = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_qn", 32'(qn), 32'hFF);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        step();

        // Single capture then pop
        d = 8'hA5;
        e = 1'b1;
        step();
        e = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'hA5);
        chk("single_q", 32'(q), 32'hA5);
        chk("single_qn", 32'(qn), 32'h5A);
        chk("single_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_pop_count", 32'(count), 32'd0);
        chk("single_pop_valid", 32'(out_valid), 32'd0);

        // Fill and overflow
        for (int i = 1; i <= 4; i++) capture(8'(i));
        chk("fill_count", 32'(count), 32'd4);
        d = 8'h05;
        e = 1'b1;
        step();
        e = 1'b0;
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_q", 32'(q), 32'h04);
        chk("ovf_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain1_data", 32'(out_data), 32'(i));
            step();
        end
        out_ready = 1'b0;
        chk("drain1_empty", 32'(out_valid), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 4; i++) capture(8'h20 + 8'(i));
        d         = 8'h66;
        e         = 1'b1;
        out_ready = 1'b1;
        step();
        e         = 1'b0;
        out_ready = 1'b0;
        chk("pp_count", 32'(count), 32'd4);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_q", 32'(q), 32'h66);
        chk("pp_full", 32'(full), 32'd1);
        out_ready = 1'b1;
        chk("pp_d0", 32'(out_data), 32'h22);
        step();
        chk("pp_d1", 32'(out_data), 32'h23);
        step();
        chk("pp_d2", 32'(out_data), 32'h24);
        step();
        chk("pp_d3", 32'(out_data), 32'h66);
        step();
        out_ready = 1'b0;
        chk("pp_empty", 32'(count), 32'd0);

        // Flush with a concurrent capture
        for (int i = 1; i <= 4; i++) capture(8'h30 + 8'(i));
        capture(8'h35);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("fl_pre_count", 32'(count), 32'd3);
        chk("fl_pre_ovf", 32'(overflow), 32'd1);
        d   = 8'h77;
        e   = 1'b1;
        clr = 1'b1;
        step();
        e   = 1'b0;
        clr = 1'b0;
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_ovf", 32'(overflow), 32'd0);
        chk("fl_q", 32'(q), 32'h34);
        chk("fl_valid", 32'(out_valid), 32'd0);
        capture(8'h88);
        chk("fl_after_data", 32'(out_data), 32'h88);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // e held high for five cycles
        e = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = 8'h10 + 8'(i);
            step();
        end
        e = 1'b0;
        chk("hold_data", 32'(out_data), 32'h10);
`ifdef D_CAPTURE_EDGE_EN
        chk("hold_count", 32'(count), 32'd1);
        chk("hold_ovf", 32'(overflow), 32'd0);
        chk("hold_q", 32'(q), 32'h10);
`else
        chk("hold_count", 32'(count), 32'd4);
        chk("hold_ovf", 32'(overflow), 32'd1);
        chk("hold_q", 32'(q), 32'h13);
`endif

        // Asynchronous reset mid-cycle with two words stored
        clr = 1'b1;
        step();
        clr = 1'b0;
        capture(8'h41);
        capture(8'h42);
        chk("ar_pre_count", 32'(count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_q", 32'(q), 32'h00);
        chk("ar_qn", 32'(qn), 32'hFF);
        chk("ar_full", 32'(full), 32'd0);
        #3;
        rst_n = 1'b1;
        step();
        chk("ar_post_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_d_capture_reader

`default_nettype wire
